computie_bus_capture: RTL and testbench

Bus-cycle capture buffer that sits directly upstream of the computie bus dumper. It snoops Computie bus cycles (address, data, direction) into a DEPTH-entry FIFO while armed. When the FIFO fills or capture is stopped, it raises `dump_start` and streams the entries to the dumper over a valid/ready handshake, flagging the final entry with `out_empty`.

---
 rtl/computie_bus_capture_if.sv | 28 ++
 rtl/computie_bus_capture.sv | 150 +++++++++++++++
 tb/tb_computie_bus_capture.sv | 278 +++++++++++++++++++++++++++
 3 files changed

// File: rtl/computie_bus_capture_if.sv
// Signal bundle between the Computie bus snooper/dumper and the capture buffer.
// The capture block takes the slave side; the bus/consumer environment takes the master side.
interface computie_bus_capture_if #(
    parameter int unsigned BITWIDTH = 32
);
    logic                  arm;
    logic                  stop;
    logic                  bus_as_n;
    logic                  bus_rw;
    logic [BITWIDTH-1:0]   bus_address;
    logic [BITWIDTH-1:0]   bus_data;
    logic                  dump_start;
    logic                  out_valid;
    logic                  out_ready;
    logic [2*BITWIDTH:0]   out_data;
    logic                  out_empty;
    logic                  overflow;

    modport master (
        output arm, stop, bus_as_n, bus_rw, bus_address, bus_data, out_ready,
        input  dump_start, out_valid, out_data, out_empty, overflow
    );

    modport slave (
        input  arm, stop, bus_as_n, bus_rw, bus_address, bus_data, out_ready,
        output dump_start, out_valid, out_data, out_empty, overflow
    );
endinterface

// File: rtl/computie_bus_capture.sv
// Snoops Computie bus cycles into a DEPTH-entry FIFO while armed, then streams
// the captured {rw, address, data} entries to the dumper over valid/ready.
module computie_bus_capture #(
    parameter int unsigned BITWIDTH = 32,
    parameter int unsigned DEPTH    = 8
) (
    input  logic                   comm_clock,
    input  logic                   comm_reset,
    computie_bus_capture_if.slave  cap
);
    localparam int unsigned PTR_W   = $clog2(DEPTH);
    localparam int unsigned CNT_W   = PTR_W + 1;
    localparam int unsigned ENTRY_W = 2 * BITWIDTH + 1;

    typedef enum logic [1:0] {
        IDLE    = 2'd0,
        CAPTURE = 2'd1,
        DRAIN   = 2'd2
    } state_t;

    state_t               state;
    logic                 as_meta;
    logic                 as_s;
    logic                 as_d;
    logic [ENTRY_W-1:0]   hold;
    logic [ENTRY_W-1:0]   mem [DEPTH];
    logic [PTR_W-1:0]     rd_ptr;
    logic [PTR_W-1:0]     wr_ptr;
    logic [PTR_W-1:0]     rd_ptr_inc;
    logic [CNT_W-1:0]     count;
    logic [CNT_W-1:0]     count_wr;
    logic                 commit;
    logic                 wr_en;
    logic                 pop;
    logic [ENTRY_W-1:0]   first_entry;

    // Strobe synchronizer plus edge-detect stage; idle level is high.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            as_meta <= 1'b1;
            as_s    <= 1'b1;
            as_d    <= 1'b1;
        end else begin
            as_meta <= cap.bus_as_n;
            as_s    <= as_meta;
            as_d    <= as_s;
        end
    end

    // Tracks the bus while the synchronized strobe is low; frozen once it rises.
    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            hold <= '0;
        end else if (!as_s) begin
            hold <= {cap.bus_rw, cap.bus_address, cap.bus_data};
        end
    end

    always_comb begin
        commit     = as_s & ~as_d;
        wr_en      = (state == CAPTURE) && commit && !cap.arm && (count < CNT_W'(DEPTH));
        pop        = (state == DRAIN) && cap.out_valid && cap.out_ready;
        rd_ptr_inc = rd_ptr + PTR_W'(1);
        count_wr   = count + CNT_W'(wr_en);
        // An empty FIFO being written on the DRAIN-entry edge presents the new entry directly.
        first_entry = (count == '0) ? hold : mem[rd_ptr];
    end

    always_ff @(posedge comm_clock) begin
        if (wr_en) begin
            mem[wr_ptr] <= hold;
        end
    end

    always_ff @(posedge comm_clock or posedge comm_reset) begin
        if (comm_reset) begin
            state          <= IDLE;
            rd_ptr         <= '0;
            wr_ptr         <= '0;
            count          <= '0;
            cap.dump_start <= 1'b0;
            cap.out_valid  <= 1'b0;
            cap.out_data   <= '0;
            cap.out_empty  <= 1'b0;
            cap.overflow   <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (cap.arm) begin
                        rd_ptr       <= '0;
                        wr_ptr       <= '0;
                        count        <= '0;
                        cap.overflow <= 1'b0;
                        state        <= CAPTURE;
                    end
                end

                CAPTURE: begin
                    if (cap.arm) begin
                        rd_ptr <= '0;
                        wr_ptr <= '0;
                        count  <= '0;
                    end else begin
                        if (wr_en) begin
                            wr_ptr <= wr_ptr + PTR_W'(1);
                            count  <= count_wr;
                        end
                        if (commit && (count == CNT_W'(DEPTH))) begin
                            cap.overflow <= 1'b1;
                        end
                        if ((wr_en && (count_wr == CNT_W'(DEPTH))) ||
                            (cap.stop && (count_wr != '0))) begin
                            state          <= DRAIN;
                            cap.dump_start <= 1'b1;
                            cap.out_valid  <= 1'b1;
                            cap.out_empty  <= (count_wr == CNT_W'(1));
                            cap.out_data   <= first_entry;
                        end else if (cap.stop) begin
                            state <= IDLE;
                        end
                    end
                end

                DRAIN: begin
                    if (commit) begin
                        cap.overflow <= 1'b1;
                    end
                    if (pop) begin
                        rd_ptr <= rd_ptr_inc;
                        count  <= count - CNT_W'(1);
                        if (count == CNT_W'(1)) begin
                            state          <= IDLE;
                            cap.dump_start <= 1'b0;
                            cap.out_valid  <= 1'b0;
                            cap.out_empty  <= 1'b0;
                            cap.out_data   <= '0;
                        end else begin
                            cap.out_data  <= mem[rd_ptr_inc];
                            cap.out_empty <= (count == CNT_W'(2));
                        end
                    end
                end

                default: begin
                    state <= IDLE;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_computie_bus_capture.sv
// Bench for computie_bus_capture: directed table vectors plus randomized rounds
// checked against a queue-based model of the capture/drain behaviour.
module tb_computie_bus_capture;
    localparam int unsigned BW    = 32;
    localparam int unsigned DEPTH = 8;

    logic comm_clock;
    logic comm_reset;

    computie_bus_capture_if #(.BITWIDTH(BW)) cap_if ();

    computie_bus_capture #(.BITWIDTH(BW), .DEPTH(DEPTH)) dut (
        .comm_clock (comm_clock),
        .comm_reset (comm_reset),
        .cap        (cap_if)
    );

    initial comm_clock = 1'b0;
    always #5 comm_clock = ~comm_clock;

    typedef struct {
        logic        rw;
        logic [31:0] addr;
        logic [31:0] data;
        logic [64:0] exp;
        logic        exp_empty;
    } vec_t;

    vec_t        vt [10];
    int          n_vec  = 0;
    int          n_miss = 0;
    logic [64:0] q [$];
    logic [64:0] got_data [$];
    logic        got_empty [$];
    bit          m_cap, m_drain, m_ovf;

    task automatic check1(input string name, input logic act, input logic exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
        end
    endtask

    task automatic checkw(input string name, input logic [64:0] act, input logic [64:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_miss++;
            $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
        end
    endtask

    task automatic model_reset();
        q.delete();
        m_cap = 0; m_drain = 0; m_ovf = 0;
    endtask

    task automatic model_commit(input logic [64:0] e);
        if (m_cap) begin
            q.push_back(e);
            if (q.size() == int'(DEPTH)) begin
                m_cap = 0; m_drain = 1;
            end
        end else if (m_drain) begin
            m_ovf = 1;
        end
    endtask

    task automatic model_arm();
        if (!m_drain) begin
            if (!m_cap) m_ovf = 0;
            m_cap = 1;
            q.delete();
        end
    endtask

    task automatic model_stop();
        if (m_cap) begin
            m_cap = 0;
            m_drain = (q.size() > 0);
        end
    endtask

    task automatic arm_pulse();
        @(posedge comm_clock); #1 cap_if.arm = 1'b1;
        @(posedge comm_clock); #1 cap_if.arm = 1'b0;
        model_arm();
    endtask

    task automatic stop_pulse();
        @(posedge comm_clock); #1 cap_if.stop = 1'b1;
        @(posedge comm_clock); #1 cap_if.stop = 1'b0;
        model_stop();
    endtask

    // One bus cycle: strobe low 4 clocks, then high until the commit has landed.
    task automatic bus_cycle(input logic rw, input logic [31:0] a, input logic [31:0] d, input bit chk_lat);
        @(posedge comm_clock); #1;
        cap_if.bus_rw = rw; cap_if.bus_address = a; cap_if.bus_data = d;
        cap_if.bus_as_n = 1'b0;
        repeat (4) @(posedge comm_clock);
        #1 cap_if.bus_as_n = 1'b1;
        for (int k = 1; k <= 4; k++) begin
            @(negedge comm_clock);
            if (chk_lat && k == 3) check1("dump_start_before_fill", cap_if.dump_start, 1'b0);
            if (chk_lat && k == 4) check1("dump_start_after_fill", cap_if.dump_start, 1'b1);
        end
        model_commit({rw, a, d});
    endtask

    task automatic rand_cycle();
        bus_cycle(1'($urandom_range(0, 1)), $urandom, $urandom, 1'b0);
    endtask

    // mode 0: ready held high, 1: ready 1,0,1,0..., 2: random ready
    task automatic drain(input int mode, input int max_pops);
        int cyc = 0;
        int pops = 0;
        logic r;
        got_data.delete();
        got_empty.delete();
        while (q.size() > 0 && pops < max_pops && cyc < 300) begin
            @(posedge comm_clock); #1;
            case (mode)
                0:       r = 1'b1;
                1:       r = (cyc % 2 == 0);
                default: r = 1'($urandom_range(0, 1));
            endcase
            cap_if.out_ready = r;
            @(negedge comm_clock);
            check1("out_valid", cap_if.out_valid, 1'b1);
            check1("dump_start", cap_if.dump_start, 1'b1);
            checkw("out_data", cap_if.out_data, q[0]);
            check1("out_empty", cap_if.out_empty, q.size() == 1);
            if (r) begin
                got_data.push_back(cap_if.out_data);
                got_empty.push_back(cap_if.out_empty);
                void'(q.pop_front());
                pops++;
            end
            cyc++;
        end
        if (cyc >= 300) begin
            n_vec++; n_miss++;
            $display("FAIL drain_timeout: %0d entries left, expected 0", q.size());
        end
        @(posedge comm_clock); #1 cap_if.out_ready = 1'b0;
        if (q.size() == 0) begin
            m_drain = 0;
            @(negedge comm_clock);
            check1("post_out_valid", cap_if.out_valid, 1'b0);
            check1("post_dump_start", cap_if.dump_start, 1'b0);
            check1("post_out_empty", cap_if.out_empty, 1'b0);
            checkw("post_out_data", cap_if.out_data, 65'd0);
            check1("post_overflow", cap_if.overflow, m_ovf);
        end
    endtask

    task automatic check_table(input string name, input int base, input int n);
        check1({name, "_count"}, got_data.size() == n, 1'b1);
        for (int i = 0; i < n && i < got_data.size(); i++) begin
            checkw({name, "_data"}, got_data[i], vt[base + i].exp);
            check1({name, "_empty"}, got_empty[i], vt[base + i].exp_empty);
        end
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        for (int i = 0; i < 8; i++) begin
            vt[i].rw        = 1'b0;
            vt[i].addr      = 32'h0000_1000 + 32'(i);
            vt[i].data      = 32'hAAAA_0000 + 32'(i);
            vt[i].exp       = {1'b0, 32'h0000_1000 + 32'(i), 32'hAAAA_0000 + 32'(i)};
            vt[i].exp_empty = (i == 7);
        end
        vt[8] = '{1'b1, 32'h1234_5678, 32'hBBBB_BBBB, {1'b1, 32'h1234_5678, 32'hBBBB_BBBB}, 1'b0};
        vt[9] = '{1'b0, 32'h2020_FFFF, 32'hAAAA_AAAA, {1'b0, 32'h2020_FFFF, 32'hAAAA_AAAA}, 1'b1};

        cap_if.arm = 0; cap_if.stop = 0; cap_if.bus_as_n = 1; cap_if.bus_rw = 0;
        cap_if.bus_address = '0; cap_if.bus_data = '0; cap_if.out_ready = 0;
        comm_reset = 1'b1;
        model_reset();
        @(negedge comm_clock);
        check1("rst_out_valid", cap_if.out_valid, 1'b0);
        check1("rst_dump_start", cap_if.dump_start, 1'b0);
        check1("rst_out_empty", cap_if.out_empty, 1'b0);
        checkw("rst_out_data", cap_if.out_data, 65'd0);
        check1("rst_overflow", cap_if.overflow, 1'b0);
        @(posedge comm_clock); #1 comm_reset = 1'b0;

        // Unarmed bus traffic is ignored.
        repeat (3) rand_cycle();
        @(negedge comm_clock);
        check1("unarmed_out_valid", cap_if.out_valid, 1'b0);
        check1("unarmed_dump_start", cap_if.dump_start, 1'b0);
        check1("unarmed_overflow", cap_if.overflow, 1'b0);

        // Fill with table writes, drain with ready held high.
        arm_pulse();
        for (int i = 0; i < 8; i++) bus_cycle(vt[i].rw, vt[i].addr, vt[i].data, i == 7);
        drain(0, 1000);
        check_table("fill8", 0, 8);
        rand_cycle();
        stop_pulse();
        @(negedge comm_clock);
        check1("back_in_idle", cap_if.out_valid, 1'b0);

        // Two cycles then stop.
        arm_pulse();
        bus_cycle(vt[8].rw, vt[8].addr, vt[8].data, 1'b0);
        bus_cycle(vt[9].rw, vt[9].addr, vt[9].data, 1'b0);
        stop_pulse();
        drain(0, 1000);
        check_table("stop2", 8, 2);

        // Overflow while stalled; arm during drain is ignored.
        arm_pulse();
        repeat (8) rand_cycle();
        rand_cycle();
        @(negedge comm_clock);
        check1("overflow_set", cap_if.overflow, 1'b1);
        arm_pulse();
        drain(2, 1000);
        check1("overflow_count", got_data.size() == 8, 1'b1);
        arm_pulse();
        @(negedge comm_clock);
        check1("overflow_cleared", cap_if.overflow, 1'b0);
        stop_pulse();
        @(negedge comm_clock);
        check1("empty_stop_idle", cap_if.out_valid, 1'b0);

        // Toggled ready.
        arm_pulse();
        repeat (4) rand_cycle();
        stop_pulse();
        drain(1, 1000);
        check1("toggle_count", got_data.size() == 4, 1'b1);

        // Reset after 3 of 8 pops.
        arm_pulse();
        repeat (8) rand_cycle();
        drain(0, 3);
        #2 comm_reset = 1'b1;
        #1;
        check1("async_out_valid", cap_if.out_valid, 1'b0);
        check1("async_dump_start", cap_if.dump_start, 1'b0);
        check1("async_out_empty", cap_if.out_empty, 1'b0);
        checkw("async_out_data", cap_if.out_data, 65'd0);
        model_reset();
        @(posedge comm_clock); #1 comm_reset = 1'b0;
        arm_pulse();
        rand_cycle();
        stop_pulse();
        drain(0, 1000);
        check1("after_reset_count", got_data.size() == 1, 1'b1);

        // Randomized rounds, including restart-by-arm and overflow.
        for (int r = 0; r < 8; r++) begin
            int n;
            n = $urandom_range(1, 11);
            arm_pulse();
            for (int j = 0; j < n; j++) begin
                rand_cycle();
                if (j == 1 && $urandom_range(0, 3) == 0) arm_pulse();
            end
            if (m_cap) stop_pulse();
            drain(2, 1000);
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
        $finish;
    end
endmodule
